// File: rtl/boot_pkg.sv
// Shared types and constants for the serial boot loader.
// The state encoding is used by the loader FSM.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE, A_LO, A_HI, L_LO, L_HI, DATA, CHK, RUN
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h55;

  function automatic int clks_per_bit(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop synchroniser, mid-bit start confirmation,
// centre sampling, one-cycle byte_valid / frame_err pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_BITS, R_STOP
  } rx_state_t;

  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);

  rx_state_t   st;
  rx_state_t   nxt;
  logic [15:0] tick;
  logic [2:0]  idx;
  logic [7:0]  sh;
  logic        s_meta;
  logic        s_rx;
  logic        s_prev;
  logic        hit_half;
  logic        hit_full;

  assign hit_half  = (tick == HALF);
  assign hit_full  = (tick == FULL);
  assign byte_data = sh;

  always_ff @(posedge clk) begin
    if (rst) st <= R_IDLE;
    else     st <= nxt;
  end

  always_comb begin
    nxt = st;
    unique case (st)
      R_IDLE:  if (s_prev && !s_rx) nxt = R_START;
      R_START: if (hit_half) nxt = s_rx ? R_IDLE : R_BITS;
      R_BITS:  if (hit_full && idx == 3'd7) nxt = R_STOP;
      R_STOP:  if (hit_full) nxt = R_IDLE;
      default: nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_meta     <= 1'b1;
      s_rx       <= 1'b1;
      s_prev     <= 1'b1;
      tick       <= '0;
      idx        <= '0;
      sh         <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      {s_prev, s_rx, s_meta} <= {s_rx, s_meta, rx};
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      // restart the bit timer on every state change and bit boundary
      if (st == R_IDLE || st != nxt || hit_full)
        tick <= '0;
      else
        tick <= tick + 16'd1;
      if (st == R_BITS && hit_full) begin
        sh  <= {s_rx, sh[7:1]};
        idx <= idx + 3'd1;
      end
      if (st == R_STOP && hit_full) begin
        byte_valid <= s_rx;
        frame_err  <= !s_rx;
      end
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Serial program loader owning the RAM write port until a GO frame,
// then a transparent CPU-to-RAM pass-through with the CPU released.
module uart_boot_loader #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dbw,
  input  logic        cpu_we,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_dbw,
  output logic        ram_we,
  output logic        cpu_rst,
  output logic        busy,
  output logic        err
);

  import boot_pkg::*;

  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ferr;
  state_t      state;
  state_t      nxt;
  logic [15:0] ptr;
  logic [15:0] cnt;
  logic [7:0]  sum;
  logic [15:0] w_addr;
  logic [7:0]  w_data;
  logic        w_we;

  uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_data (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (rx_ferr)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (rx_ferr) begin
      if (state != IDLE && state != RUN) nxt = IDLE;
    end else if (rx_valid) begin
      unique case (state)
        IDLE: if (rx_byte == SYNC_BYTE) nxt = A_LO;
        A_LO: nxt = A_HI;
        A_HI: nxt = L_LO;
        L_LO: nxt = L_HI;
        L_HI: nxt = ({rx_byte, cnt[7:0]} == 16'h0) ? RUN : DATA;
        DATA: if (cnt == 16'd1) nxt = CHK;
        CHK:  nxt = IDLE;
        RUN:  nxt = RUN;
        default: nxt = IDLE;
      endcase
    end
  end

  // cpu_rst comes straight from state so release and mux switch coincide
  always_comb begin
    busy     = 1'b0;
    cpu_rst  = 1'b1;
    ram_addr = w_addr;
    ram_dbw  = w_data;
    ram_we   = w_we;
    unique case (state)
      IDLE: busy = 1'b0;
      RUN: begin
        cpu_rst  = 1'b0;
        ram_addr = cpu_addr;
        ram_dbw  = cpu_dbw;
        ram_we   = cpu_we;
      end
      default: busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      cnt    <= '0;
      sum    <= '0;
      w_addr <= '0;
      w_data <= '0;
      w_we   <= 1'b0;
      err    <= 1'b0;
    end else begin
      w_we <= 1'b0;
      if (rx_ferr && state != RUN) err <= 1'b1;
      if (rx_valid) begin
        unique case (state)
          IDLE: if (rx_byte == SYNC_BYTE) err <= 1'b0;
          A_LO: ptr[7:0]  <= rx_byte;
          A_HI: ptr[15:8] <= rx_byte;
          L_LO: cnt[7:0]  <= rx_byte;
          L_HI: begin
            cnt[15:8] <= rx_byte;
            sum       <= '0;
          end
          DATA: begin
            w_addr <= ptr;
            w_data <= rx_byte;
            w_we   <= 1'b1;
            sum    <= sum + rx_byte;
            ptr    <= ptr + 16'd1;
            cnt    <= cnt - 16'd1;
          end
          CHK: if (rx_byte != sum) err <= 1'b1;
          RUN: err <= err;
          default: err <= err;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench: serial frames in, RAM write log and status checked
// against hand-computed expectations.
module tb_uart_boot_loader;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;
  localparam int CPB    = CLK_HZ / BAUD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [15:0] cpu_addr = 16'hBEEF;
  logic [7:0]  cpu_dbw  = 8'hC3;
  logic        cpu_we   = 1'b1;
  logic [15:0] ram_addr;
  logic [7:0]  ram_dbw;
  logic        ram_we;
  logic        cpu_rst;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [23:0] wq[$];

  logic [7:0] f1[9]  = '{8'h55, 8'h00, 8'h02, 8'h03, 8'h00,
                         8'hAA, 8'hBB, 8'hCC, 8'h31};
  logic [7:0] f2[8]  = '{8'h55, 8'hFF, 8'hFF, 8'h02, 8'h00,
                         8'h11, 8'h22, 8'h33};
  logic [7:0] f3[7]  = '{8'h55, 8'h00, 8'h03, 8'h01, 8'h00,
                         8'h7E, 8'h7F};
  logic [7:0] f4[5]  = '{8'h55, 8'h00, 8'h04, 8'h02, 8'h00};
  logic [7:0] f5[6]  = '{8'h55, 8'h10, 8'h05, 8'h03, 8'h00,
                         8'h01};
  logic [7:0] f6[8]  = '{8'h55, 8'h10, 8'h05, 8'h02, 8'h00,
                         8'h21, 8'h43, 8'h64};
  logic [7:0] go[7]  = '{8'h00, 8'h13, 8'h55, 8'h00, 8'h00,
                         8'h00, 8'h00};

  uart_boot_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .cpu_addr(cpu_addr),
    .cpu_dbw (cpu_dbw),
    .cpu_we  (cpu_we),
    .ram_addr(ram_addr),
    .ram_dbw (ram_dbw),
    .ram_we  (ram_we),
    .cpu_rst (cpu_rst),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  // log every loader-side write cycle as {addr, data}
  always @(negedge clk)
    if (ram_we && cpu_rst) wq.push_back({ram_addr, ram_dbw});

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] wr(input int i);
    if (i < wq.size()) return wq[i];
    return 24'hxxxxxx;
  endfunction

  task automatic send_byte(
    input logic [7:0] b,
    input logic       stop
  );
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_dbw", ram_dbw, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);

    // basic 3-byte load
    wq.delete();
    send_byte(f1[0], 1'b1);
    chk("f1_busy_hdr", busy, 1);
    for (int i = 1; i < 9; i++) send_byte(f1[i], 1'b1);
    chk("f1_n", wq.size(), 3);
    chk("f1_w0", wr(0), 24'h0200AA);
    chk("f1_w1", wr(1), 24'h0201BB);
    chk("f1_w2", wr(2), 24'h0202CC);
    chk("f1_err", err, 0);
    chk("f1_busy", busy, 0);
    chk("f1_cpu_rst", cpu_rst, 1);

    // address wrap
    wq.delete();
    foreach (f2[i]) send_byte(f2[i], 1'b1);
    chk("f2_n", wq.size(), 2);
    chk("f2_w0", wr(0), 24'hFFFF11);
    chk("f2_w1", wr(1), 24'h000022);
    chk("f2_err", err, 0);

    // bad checksum, then sync clears err
    wq.delete();
    foreach (f3[i]) send_byte(f3[i], 1'b1);
    chk("f3_n", wq.size(), 1);
    chk("f3_w0", wr(0), 24'h03007E);
    chk("f3_err", err, 1);
    chk("f3_busy", busy, 0);

    // sync clears err; stop bit 0 in DATA aborts
    wq.delete();
    foreach (f4[i]) send_byte(f4[i], 1'b1);
    chk("f4_err_clr", err, 0);
    chk("f4_busy", busy, 1);
    send_byte(8'h44, 1'b0);
    chk("ferr_n", wq.size(), 0);
    chk("ferr_err", err, 1);
    chk("ferr_busy", busy, 0);

    // short glitch on idle line
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    chk("glitch_n", wq.size(), 0);
    chk("glitch_busy", busy, 0);
    chk("glitch_err", err, 1);

    // reset mid-DATA, then a fresh frame
    wq.delete();
    foreach (f5[i]) send_byte(f5[i], 1'b1);
    chk("f5_n", wq.size(), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_addr", ram_addr, 0);
    chk("mrst_dbw", ram_dbw, 0);
    chk("mrst_we", ram_we, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_err", err, 0);
    chk("mrst_cpu_rst", cpu_rst, 1);
    rst = 1'b0;
    @(negedge clk);
    wq.delete();
    foreach (f6[i]) send_byte(f6[i], 1'b1);
    chk("f6_n", wq.size(), 2);
    chk("f6_w0", wr(0), 24'h051021);
    chk("f6_w1", wr(1), 24'h051143);
    chk("f6_err", err, 0);

    // garbage then GO
    wq.delete();
    send_byte(go[0], 1'b1);
    send_byte(go[1], 1'b1);
    chk("go_garbage_busy", busy, 0);
    for (int i = 2; i < 7; i++) send_byte(go[i], 1'b1);
    chk("go_cpu_rst", cpu_rst, 0);
    chk("go_busy", busy, 0);
    chk("go_n", wq.size(), 0);
    cpu_addr = 16'h1234;
    cpu_dbw  = 8'h5A;
    cpu_we   = 1'b1;
    #1;
    chk("pt_addr", ram_addr, 16'h1234);
    chk("pt_dbw", ram_dbw, 8'h5A);
    chk("pt_we", ram_we, 1);
    cpu_we = 1'b0;
    #1;
    chk("pt_we0", ram_we, 0);
    send_byte(8'h55, 1'b1);
    chk("run_busy", busy, 0);
    chk("run_cpu_rst", cpu_rst, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Sits directly upstream of the 64 KB SPRAM ram block and owns its write port at power-up.
- Receives framed program images over a serial RX pin, writes each byte into RAM, then releases the 6502 from reset.
- After release it becomes a transparent pass-through of the CPU address, data and write-enable onto the RAM.

Parameters:
CLK_HZ, 12000000, system clock frequency in Hz
BAUD, 115200, serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer, truncated)

Ports:
clk  in  1  system clock; the block's only clock
rst  in  1  synchronous, active-high reset
rx  in  1  asynchronous serial input; idles high, 8N1
cpu_addr  in  16  CPU address bus
cpu_dbw  in  8  CPU write data
cpu_we  in  1  CPU write strobe
ram_addr  out  16  to ram addr
ram_dbw  out  8  to ram dbw
ram_we  out  1  to ram we
cpu_rst  out  1  active-high CPU reset, held until a GO frame is received
busy  out  1  high while a frame is in progress (state is neither IDLE nor RUN)
err  out  1  sticky error flag; set on checksum or framing error, cleared on the next accepted sync byte

Behaviour:
- Reset values: cpu_rst=1, ram_we=0, ram_addr=0, ram_dbw=0, busy=0, err=0, state=IDLE.
- RX front end:
  - 2-flop synchroniser on rx.
  - Start bit is detected on a falling edge and confirmed at mid-bit (CLKS_PER_BIT/2); a high sample there is a glitch and is ignored.
  - 8 data bits, LSB first, each sampled at bit centre.
  - Stop bit sampled: 1 gives a one-cycle byte_valid pulse; 0 gives a one-cycle frame_err pulse and no byte.
- Frame format: 0x55 sync, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, LEN data bytes, CHK.
  - CHK is the 8-bit modulo-256 sum of the data bytes.
  - LEN=0 marks a GO frame; it has no data bytes and no CHK.
- FSM states: IDLE, A_LO, A_HI, L_LO, L_HI, DATA, CHK, RUN. Transitions happen only on byte_valid unless noted.
  - IDLE: byte 0x55 goes to A_LO and clears err. Any other byte is discarded.
  - A_LO/A_HI: latch ptr[7:0] and ptr[15:8].
  - L_LO/L_HI: latch cnt. On leaving L_HI, cnt==0 goes to RUN; otherwise go to DATA with sum=0.
  - DATA: each byte issues a RAM write and sets sum+=byte, ptr+=1, cnt-=1. cnt reaching 0 goes to CHK.
  - CHK: byte==sum goes to IDLE. Mismatch sets err and goes to IDLE. RAM contents already written are not rolled back.
  - RUN: terminal until rst; all bytes are ignored.
- RAM write timing: the cycle after byte_valid in DATA, ram_addr=ptr (pre-increment value), ram_dbw=byte and ram_we=1. ram_we stays high for exactly one cycle; outputs are registered.
- Address wrap: ptr increments modulo 2^16, so 0xFFFF is followed by 0x0000.
- Length: 1 to 65535; LEN=0 is reserved for GO.
- No back-pressure is needed: bytes arrive at least 10*CLKS_PER_BIT cycles apart.
- frame_err in any state other than IDLE or RUN sets err and returns to IDLE. In IDLE it sets err only. In RUN it is ignored.
- Bus mux:
  - State != RUN: RAM ports are driven from the loader registers; cpu_* inputs are ignored and ram_we=0 except during write pulses.
  - State == RUN: combinational pass-through, ram_addr=cpu_addr, ram_dbw=cpu_dbw, ram_we=cpu_we.
- cpu_rst: falls to 0 in the same cycle the state becomes RUN, so the mux switch and the reset release coincide.
- rst asserted at any time, including mid-frame or mid-byte, returns every register to its reset value on the next edge. No partial write is issued.

Decomposition:
- Package boot_pkg holds: the state enum typedef, SYNC_BYTE=8'h55, and the CLKS_PER_BIT derivation function.
- Sub-module uart_rx (ports: clk, rst, rx, byte_data[7:0], byte_valid, frame_err) contains the synchroniser and bit timer. uart_boot_loader instantiates it once.

Test Plan:
- Frame 55 00 02 03 00 | AA BB CC | 31 -> writes 0x0200=AA, 0x0201=BB, 0x0202=CC, one ram_we pulse each. err=0, busy drops after CHK, cpu_rst still 1.
- Frame 55 FF FF 02 00 | 11 22 | 33 -> writes 0xFFFF=11 then 0x0000=22 (wrap).
- Frame 55 00 03 01 00 | 7E | 7F -> 0x0300=7E written, err=1, state IDLE. A following 55 clears err.
- Bytes 00 13 55 00 00 00 00 (garbage then GO frame) -> garbage ignored, cpu_rst falls. Afterwards cpu_addr=0x1234, cpu_dbw=5A, cpu_we=1 appear unchanged on the ram_* outputs the same cycle.
- Byte with stop bit 0 during DATA -> no write, err=1, IDLE. A glitch shorter than CLKS_PER_BIT/2 on idle rx -> no byte.
- rst pulsed mid-DATA (after 1 of 3 bytes) -> all outputs at reset values. The next full frame loads correctly from its own header.
